// File: rtl/debug_slave_sysclk_cmd.sv
// ----------------------------------------------------------------------------
// debug_slave_sysclk_cmd
//
// System-clock side of the JTAG debug slave. Toggle-encoded update-DR and
// update-IR strobes from the TCK domain are synchronised into i_clk. On each
// update-DR event the scan word is captured into o_jdo, and one of two things
// is issued on channel i_ir_in:
//   - a held valid/ready action request, or
//   - a one-cycle no-action pulse.
// A command that arrives while any request is still pending is dropped, and
// a sticky overrun flag is set for its channel.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_sr           scan register (TCK domain, stable between udr toggles)
//   i_ir_in        IR value (TCK domain, quasi-static)
//   i_udr_tgl      toggles once per update-DR
//   i_uir_tgl      toggles once per update-IR
//   i_act_ready    per-channel accept for pending action requests
//   i_overrun_clr  clears all overrun flags
//   o_jdo          captured scan word
//   o_act_valid    per-channel action request, held until accepted
//   o_noact_pulse  per-channel one-cycle no-action strobe
//   o_ir_changed   one-cycle pulse per update-IR
//   o_overrun      per-channel sticky dropped-command flag
//   o_st_idle      high when no action request is pending
// ----------------------------------------------------------------------------
module debug_slave_sysclk_cmd #(
    parameter int unsigned SR_W        = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned ACT_BIT     = 35,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [SR_W-1:0]         i_sr,
    input  logic [IR_W-1:0]         i_ir_in,
    input  logic                    i_udr_tgl,
    input  logic                    i_uir_tgl,
    input  logic [(1<<IR_W)-1:0]    i_act_ready,
    input  logic                    i_overrun_clr,
    output logic [SR_W-1:0]         o_jdo,
    output logic [(1<<IR_W)-1:0]    o_act_valid,
    output logic [(1<<IR_W)-1:0]    o_noact_pulse,
    output logic                    o_ir_changed,
    output logic [(1<<IR_W)-1:0]    o_overrun,
    output logic                    o_st_idle
);

    localparam int unsigned NCH      = 1 << IR_W;
    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned CNT_W    = $clog2(WARM_MAX + 1);

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_edge;
    logic                   r_uir_edge;
    logic [CNT_W-1:0]       r_warm_cnt;

    logic [SR_W-1:0]        r_jdo;
    logic [NCH-1:0]         r_act_valid;
    logic [NCH-1:0]         r_noact_pulse;
    logic                   r_ir_changed;
    logic [NCH-1:0]         r_overrun;

    logic                   w_warm_done;
    logic                   w_udr_ev;
    logic                   w_uir_ev;
    logic [NCH-1:0]         w_ch_oh;
    logic                   w_busy;
    logic                   w_accept;
    logic [SR_W-1:0]        w_jdo_d;
    logic [NCH-1:0]         w_act_valid_d;
    logic [NCH-1:0]         w_noact_d;
    logic [NCH-1:0]         w_overrun_d;

    // Edge flops keep tracking during warm-up so a toggle input that sits
    // high out of reset is absorbed without producing an event.
    assign w_warm_done = (r_warm_cnt == CNT_W'(WARM_MAX));
    assign w_udr_ev    = w_warm_done & (r_udr_sync[SYNC_STAGES-1] ^ r_udr_edge);
    assign w_uir_ev    = w_warm_done & (r_uir_sync[SYNC_STAGES-1] ^ r_uir_edge);

    always_comb begin
        w_ch_oh       = NCH'(1) << i_ir_in;
        w_busy        = |(r_act_valid & ~i_act_ready);
        w_accept      = w_udr_ev & ~w_busy;
        w_act_valid_d = r_act_valid & ~i_act_ready;
        w_noact_d     = '0;
        w_jdo_d       = r_jdo;
        w_overrun_d   = i_overrun_clr ? '0 : r_overrun;
        if (w_accept) begin
            w_jdo_d = i_sr;
            if (i_sr[ACT_BIT]) begin
                w_act_valid_d = w_act_valid_d | w_ch_oh;
            end else begin
                w_noact_d = w_ch_oh;
            end
        end
        // Applied after the clear so a same-cycle set wins on its channel.
        if (w_udr_ev && w_busy) begin
            w_overrun_d = w_overrun_d | w_ch_oh;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_udr_sync    <= '0;
            r_uir_sync    <= '0;
            r_udr_edge    <= 1'b0;
            r_uir_edge    <= 1'b0;
            r_warm_cnt    <= '0;
            r_jdo         <= '0;
            r_act_valid   <= '0;
            r_noact_pulse <= '0;
            r_ir_changed  <= 1'b0;
            r_overrun     <= '0;
        end else begin
            r_udr_sync    <= {r_udr_sync[SYNC_STAGES-2:0], i_udr_tgl};
            r_uir_sync    <= {r_uir_sync[SYNC_STAGES-2:0], i_uir_tgl};
            r_udr_edge    <= r_udr_sync[SYNC_STAGES-1];
            r_uir_edge    <= r_uir_sync[SYNC_STAGES-1];
            if (!w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + CNT_W'(1);
            end
            r_jdo         <= w_jdo_d;
            r_act_valid   <= w_act_valid_d;
            r_noact_pulse <= w_noact_d;
            r_ir_changed  <= w_uir_ev;
            r_overrun     <= w_overrun_d;
        end
    end

    assign o_jdo         = r_jdo;
    assign o_act_valid   = r_act_valid;
    assign o_noact_pulse = r_noact_pulse;
    assign o_ir_changed  = r_ir_changed;
    assign o_overrun     = r_overrun;
    assign o_st_idle     = ~|r_act_valid;

endmodule

// File: tb/tb_debug_slave_sysclk_cmd.sv
// ----------------------------------------------------------------------------
// tb_debug_slave_sysclk_cmd
//
// Self-checking bench for debug_slave_sysclk_cmd with default parameters.
// Expected post-command state is pushed to a scoreboard queue as each udr
// toggle is driven and popped at the capture edge (E0+2).
// ----------------------------------------------------------------------------
module tb_debug_slave_sysclk_cmd;

    typedef struct {
        logic [37:0] jdo;
        logic [3:0]  av;
        logic [3:0]  na;
        logic [3:0]  ov;
    } exp_t;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  rdy;
        logic [37:0] jdo;
        logic [3:0]  av;
        logic [3:0]  na;
        logic [3:0]  ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] sr;
    logic [1:0]  ir_in;
    logic        udr_tgl;
    logic        uir_tgl;
    logic [3:0]  act_ready;
    logic        overrun_clr;
    logic [37:0] jdo;
    logic [3:0]  act_valid;
    logic [3:0]  noact_pulse;
    logic        ir_changed;
    logic [3:0]  overrun;
    logic        st_idle;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [37:0] m_jdo;
    vec_t        vt[8];

    always #5 clk = ~clk;

    debug_slave_sysclk_cmd dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_sr          (sr),
        .i_ir_in       (ir_in),
        .i_udr_tgl     (udr_tgl),
        .i_uir_tgl     (uir_tgl),
        .i_act_ready   (act_ready),
        .i_overrun_clr (overrun_clr),
        .o_jdo         (jdo),
        .o_act_valid   (act_valid),
        .o_noact_pulse (noact_pulse),
        .o_ir_changed  (ir_changed),
        .o_overrun     (overrun),
        .o_st_idle     (st_idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [37:0] j, input logic [3:0] av, input logic [3:0] na,
                        input logic [3:0] ov);
        exp_t e;
        e.jdo = j;
        e.av  = av;
        e.na  = na;
        e.ov  = ov;
        sb.push_back(e);
    endtask

    // Drives one udr toggle (optionally with uir), applies rdy/clr in the
    // event cycle, and compares the capture edge against the scoreboard.
    task automatic udr_cmd(input string nm, input logic [1:0] a_ir, input logic [37:0] a_sr,
                           input logic [3:0] rdy, input logic clr, input logic with_uir);
        exp_t e;
        ir_in   = a_ir;
        sr      = a_sr;
        udr_tgl = ~udr_tgl;
        if (with_uir) uir_tgl = ~uir_tgl;
        tick();                               // E0
        tick();                               // E0+1
        chk({nm, "_lat_jdo"}, 64'(jdo), 64'(m_jdo));
        chk({nm, "_lat_na"}, 64'(noact_pulse), 64'd0);
        if (with_uir) chk({nm, "_lat_irc"}, 64'(ir_changed), 64'd0);
        act_ready   = rdy;
        overrun_clr = clr;
        tick();                               // E0+2
        act_ready   = '0;
        overrun_clr = 1'b0;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_jdo"}, 64'(jdo), 64'(e.jdo));
            chk({nm, "_av"}, 64'(act_valid), 64'(e.av));
            chk({nm, "_na"}, 64'(noact_pulse), 64'(e.na));
            chk({nm, "_ov"}, 64'(overrun), 64'(e.ov));
            chk({nm, "_idle"}, 64'(st_idle), 64'(e.av == 4'b0));
            if (with_uir) chk({nm, "_irc"}, 64'(ir_changed), 64'd1);
            m_jdo = e.jdo;
            tick();
            chk({nm, "_na_1cyc"}, 64'(noact_pulse), 64'd0);
            chk({nm, "_av_hold"}, 64'(act_valid), 64'(e.av));
            if (with_uir) chk({nm, "_irc_1cyc"}, 64'(ir_changed), 64'd0);
        end
    endtask

    initial begin
        // {ir, sr, ready-in-event-cycle, jdo, act_valid, noact, overrun}
        vt[0] = '{2'd2, 38'h2_0000_1234, 4'b0000, 38'h2_0000_1234, 4'b0000, 4'b0100, 4'b0000};
        vt[1] = '{2'd1, 38'h8_0000_0055, 4'b0000, 38'h8_0000_0055, 4'b0010, 4'b0000, 4'b0000};
        vt[2] = '{2'd3, 38'h0_0000_FFFF, 4'b0000, 38'h8_0000_0055, 4'b0010, 4'b0000, 4'b1000};
        vt[3] = '{2'd1, 38'h9_0000_00AA, 4'b0010, 38'h9_0000_00AA, 4'b0010, 4'b0000, 4'b1000};
        vt[4] = '{2'd0, 38'h3_0000_0001, 4'b0010, 38'h3_0000_0001, 4'b0000, 4'b0001, 4'b1000};
        vt[5] = '{2'd0, 38'h8_ABCD_0000, 4'b1010, 38'h8_ABCD_0000, 4'b0001, 4'b0000, 4'b1000};
        vt[6] = '{2'd2, 38'h8_0000_0002, 4'b0001, 38'h8_0000_0002, 4'b0100, 4'b0000, 4'b1000};
        vt[7] = '{2'd2, 38'h8_1111_1111, 4'b0000, 38'h8_0000_0002, 4'b0100, 4'b0000, 4'b1100};

        // Reset with both toggles sitting high.
        reset       = 1'b1;
        sr          = 38'h8_FFFF_FFFF;
        ir_in       = 2'd1;
        udr_tgl     = 1'b1;
        uir_tgl     = 1'b1;
        act_ready   = '0;
        overrun_clr = 1'b0;
        m_jdo       = '0;
        tick();
        tick();
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_av", 64'(act_valid), 64'd0);
        chk("rst_idle", 64'(st_idle), 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("warm%0d_av", i), 64'(act_valid), 64'd0);
            chk($sformatf("warm%0d_na", i), 64'(noact_pulse), 64'd0);
            chk($sformatf("warm%0d_jdo", i), 64'(jdo), 64'd0);
            chk($sformatf("warm%0d_irc", i), 64'(ir_changed), 64'd0);
            chk($sformatf("warm%0d_idle", i), 64'(st_idle), 64'd1);
        end

        for (int i = 0; i < 8; i++) begin
            push(vt[i].jdo, vt[i].av, vt[i].na, vt[i].ov);
            udr_cmd($sformatf("vec%0d", i), vt[i].ir, vt[i].sr, vt[i].rdy, 1'b0, 1'b0);
        end

        // Overrun clear, then release of the held ch2 request.
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr_ov", 64'(overrun), 64'd0);
        chk("clr_av_kept", 64'(act_valid), 64'b0100);
        tick();
        chk("hold_av", 64'(act_valid), 64'b0100);
        act_ready = 4'b0100;
        tick();
        act_ready = '0;
        chk("rel_av", 64'(act_valid), 64'd0);
        chk("rel_idle", 64'(st_idle), 64'd1);

        // Clear coincident with a new overrun: set wins on ch3, ch0 clears.
        push(38'h8_0000_0777, 4'b0010, 4'b0000, 4'b0000);
        udr_cmd("ovs_a", 2'd1, 38'h8_0000_0777, 4'b0000, 1'b0, 1'b0);
        push(38'h8_0000_0777, 4'b0010, 4'b0000, 4'b0001);
        udr_cmd("ovs_b", 2'd0, 38'h0_0000_0001, 4'b0000, 1'b0, 1'b0);
        push(38'h8_0000_0777, 4'b0010, 4'b0000, 4'b1000);
        udr_cmd("ovs_c", 2'd3, 38'h0_0000_0BAD, 4'b0000, 1'b1, 1'b0);
        act_ready = 4'b0010;
        tick();
        act_ready = '0;
        chk("ovs_rel_av", 64'(act_valid), 64'd0);

        // Simultaneous uir and udr.
        push(38'h1_2345_6789, 4'b0000, 4'b1000, 4'b1000);
        udr_cmd("both", 2'd3, 38'h1_2345_6789, 4'b0000, 1'b0, 1'b1);

        // uir alone: pulse only.
        uir_tgl = ~uir_tgl;
        tick();
        tick();
        chk("uir_lat", 64'(ir_changed), 64'd0);
        tick();
        chk("uir_pulse", 64'(ir_changed), 64'd1);
        chk("uir_jdo", 64'(jdo), 64'h1_2345_6789);
        chk("uir_na", 64'(noact_pulse), 64'd0);
        tick();
        chk("uir_1cyc", 64'(ir_changed), 64'd0);

        // Reset mid-request, then a command after the warm-up window.
        push(38'h8_0000_0F0F, 4'b0100, 4'b0000, 4'b1000);
        udr_cmd("prerst", 2'd2, 38'h8_0000_0F0F, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("mrst_jdo", 64'(jdo), 64'd0);
        chk("mrst_av", 64'(act_valid), 64'd0);
        chk("mrst_ov", 64'(overrun), 64'd0);
        chk("mrst_idle", 64'(st_idle), 64'd1);
        reset = 1'b0;
        m_jdo = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_av", 64'(act_valid), 64'd0);
        chk("post_na", 64'(noact_pulse), 64'd0);
        push(38'h0_0000_00C3, 4'b0000, 4'b0001, 4'b0000);
        udr_cmd("post", 2'd0, 38'h0_0000_00C3, 4'b0000, 1'b0, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
